ring4b_monitor: RTL and testbench
=================================

// Module: ring4b_monitor
// PURPOSE
//  Receive-side checker/decoder for the N-bit one-hot ring counter (ring4b output bus).
//  Samples the ring code each enabled clock, decodes it to a binary index, flags
//  non-one-hot codes and out-of-sequence steps, and tracks lock to the ring sequence.
//  Sits downstream of ring4b on the same Clk; used in self-checking benches and as a
//  fault monitor for the counter chain.
// PARAMETERS
//  N        4        ring width (bits in one-hot code), N>=2
//  DIR      0        0: rotate left (Q[i]->Q[i+1], Q[N-1]->Q[0]); 1: rotate right
//  LOCK_CNT 3        consecutive legal, in-sequence samples (incl. first) needed to lock
//  ERR_W    8        width of saturating error counter
// PORTS
//  Clk     in   1        clock, rising edge
//  Ori     in   1        reset: asynchronous, active-high
//  En      in   1        sample enable; Q observed only on posedges with En=1
//  Q       in   N        ring code from counter
//  Idx     out  IDX_W    binary index of set bit (IDX_W = clog2(N), min 1)
//  Valid   out  1        Idx holds a legal decode of the last sample
//  Illegal out  1        1-cycle pulse: last sample not exactly one-hot
//  SeqErr  out  1        1-cycle pulse: last sample one-hot but != expected rotation
//  Locked  out  1        monitor locked to ring sequence
//  ErrCnt  out  ERR_W    saturating count of Illegal+SeqErr events
// BEHAVIOUR
//  - Reset (Ori=1, async): Idx=0, Valid=0, Illegal=0, SeqErr=0, Locked=0, ErrCnt=0,
//    state=SEARCH, prev code=0, good count=0. Outputs clear immediately, not at edge.
//  - All outputs registered; latency 1 cycle from sampling edge to output update.
//  - En=0: state, Idx, Valid, Locked, ErrCnt hold; Illegal/SeqErr forced 0.
//  - Legal = popcount(Q)==1. Expected = prev rotated one place per DIR (wraps MSB<->LSB).
//  - Illegal has priority: an illegal sample never raises SeqErr. Illegal -> Valid=0, Idx holds.
//  - Legal sample -> Idx=position of set bit, Valid=1, prev<=Q (even when SeqErr).
//  - Unchanged code (Q==prev) on an enabled edge counts as SeqErr (stuck counter).
//  - FSM (state updates only when En=1):
//    SEARCH : legal -> ACQUIRE, good=1 (LOCK_CNT==1 -> LOCKED); illegal -> stay, Illegal.
//             No SeqErr in SEARCH (no reference).
//    ACQUIRE: legal&expected -> good++; good reaches LOCK_CNT -> LOCKED.
//             legal&unexpected -> SeqErr, stay, good=1; illegal -> Illegal, SEARCH, good=0.
//    LOCKED : legal&expected -> stay. legal&unexpected -> SeqErr, ACQUIRE, good=1.
//             illegal -> Illegal, SEARCH, good=0. Locked=1 only in LOCKED.
//  - ErrCnt += 1 per Illegal or SeqErr pulse; saturates at 2^ERR_W-1, never wraps.
//  - good counter width clog2(LOCK_CNT+1); saturates at LOCK_CNT.
// STRUCTURE
//  - Shared header ring_defs.vh: FSM state encodings (SEARCH=2'd0, ACQUIRE=2'd1,
//    LOCKED=2'd2), DIR_LEFT/DIR_RIGHT constants, clog2 function for IDX_W.
//  - One sub-module: onehot_dec (combinational, param N): Q -> {legal, idx}.
//  - Top: rotate/compare logic, FSM, output regs, saturating counter.
// TESTING (N=4, DIR=0, LOCK_CNT=3, Clk period 40ns, En=1 unless noted)
//  1 Ori pulse, then Q=0001,0010,0100,1000,0001 -> Idx 0,1,2,3,0; Valid=1; Locked rises
//    the cycle after the 3rd sample (0100); no error pulses; ErrCnt=0.
//  2 Locked, Q=0110 -> Illegal=1 one cycle, Valid=0, Locked=0, ErrCnt=1, SeqErr=0.
//  3 Locked at 0001, next Q=0100 (skip) -> SeqErr=1, Idx=2, Valid=1, Locked=0, ErrCnt=1;
//    then 1000,0001 -> Locked=1 again after 0001.
//  4 Stuck Q=0010,0010 while locked -> SeqErr on 2nd; En=0 with Q=1111 -> no pulses, all hold.
//  5 ERR_W=2, feed 5 illegal codes (0000) -> ErrCnt 1,2,3,3,3 (saturates, no wrap).
//  6 Locked, assert Ori between edges -> all outputs 0 before next posedge; release,
//    legal sequence re-locks after 3 samples.

Source files
------------

// File: rtl/ring4b_monitor_pkg.sv
// Shared definitions for the ring4b monitor: FSM state encoding, rotation
// direction constants and a width helper.
`default_nettype none

package ring4b_monitor_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;

  // Ceiling log2 with a floor of 1 so single-value ranges still get a bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ring4b_monitor_onehot_dec.sv
// Combinational one-hot decoder: flags whether the code has exactly one bit set
// and returns the position of that bit.
`default_nettype none

module ring4b_monitor_onehot_dec
  import ring4b_monitor_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     q_i,
  output logic             legal_o,
  output logic [IDX_W-1:0] idx_o
);

  logic seen;
  logic multi;

  // OR-ing indices is exact whenever only one bit is set; otherwise idx is unused.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (q_i[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        idx_o = idx_o | IDX_W'(i);
      end
    end
    legal_o = seen & ~multi;
  end

endmodule

`default_nettype wire

// File: rtl/ring4b_monitor.sv
// Receive-side checker for a one-hot ring counter: decodes the code, flags
// illegal and out-of-sequence samples, tracks lock and counts errors.
`default_nettype none

module ring4b_monitor
  import ring4b_monitor_pkg::*;
#(
  parameter int N        = 4,
  parameter int DIR      = DIR_LEFT,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  localparam int IDX_W   = clog2_min1(N)
) (
  input  logic             Clk,
  input  logic             Ori,
  input  logic             En,
  input  logic [N-1:0]     Q,
  output logic [IDX_W-1:0] Idx,
  output logic             Valid,
  output logic             Illegal,
  output logic             SeqErr,
  output logic             Locked,
  output logic [ERR_W-1:0] ErrCnt
);

  localparam int GOOD_W = clog2_min1(LOCK_CNT + 1);

  state_e             state_q, state_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [N-1:0]       prev_q, prev_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               illegal_q, illegal_d;
  logic               seqerr_q, seqerr_d;
  logic [ERR_W-1:0]   errcnt_q, errcnt_d;

  logic               dec_legal;
  logic [IDX_W-1:0]   dec_idx;
  logic [N-1:0]       expected;
  logic               in_seq;

  ring4b_monitor_onehot_dec #(.N(N)) u_dec (
    .q_i     (Q),
    .legal_o (dec_legal),
    .idx_o   (dec_idx)
  );

  // A repeated code never equals its own rotation, so a stuck counter reads as out of sequence.
  assign expected = (DIR == DIR_RIGHT) ? {prev_q[0], prev_q[N-1:1]}
                                       : {prev_q[N-2:0], prev_q[N-1]};
  assign in_seq   = (Q == expected);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    prev_d    = prev_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    illegal_d = 1'b0;
    seqerr_d  = 1'b0;
    errcnt_d  = errcnt_q;

    if (En) begin
      if (!dec_legal) begin
        illegal_d = 1'b1;
        valid_d   = 1'b0;
        state_d   = SEARCH;
        good_d    = '0;
      end else begin
        idx_d   = dec_idx;
        valid_d = 1'b1;
        prev_d  = Q;
        case (state_q)
          SEARCH: begin
            good_d  = GOOD_W'(1);
            state_d = (LOCK_CNT <= 1) ? LOCKED : ACQUIRE;
          end
          ACQUIRE: begin
            if (in_seq) begin
              if (good_q >= GOOD_W'(LOCK_CNT - 1)) begin
                good_d  = GOOD_W'(LOCK_CNT);
                state_d = LOCKED;
              end else begin
                good_d = good_q + GOOD_W'(1);
              end
            end else begin
              seqerr_d = 1'b1;
              good_d   = GOOD_W'(1);
            end
          end
          LOCKED: begin
            if (!in_seq) begin
              seqerr_d = 1'b1;
              good_d   = GOOD_W'(1);
              state_d  = ACQUIRE;
            end
          end
          default: begin
            state_d = SEARCH;
            good_d  = '0;
          end
        endcase
      end

      if ((illegal_d || seqerr_d) && (errcnt_q != {ERR_W{1'b1}})) begin
        errcnt_d = errcnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Ori) begin
    if (Ori) begin
      state_q   <= SEARCH;
      good_q    <= '0;
      prev_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      seqerr_q  <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      prev_q    <= prev_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      seqerr_q  <= seqerr_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign Idx     = idx_q;
  assign Valid   = valid_q;
  assign Illegal = illegal_q;
  assign SeqErr  = seqerr_q;
  assign Locked  = (state_q == LOCKED);
  assign ErrCnt  = errcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ring4b_monitor.sv
// Directed bench for ring4b_monitor (N=4, rotate left, LOCK_CNT=3) plus an
// ERR_W=2 instance for counter saturation.
`default_nettype none

module tb_ring4b_monitor;

  typedef struct packed {
    logic [3:0] q;
    logic [1:0] idx;
    logic       v;
    logic       il;
    logic       se;
    logic       lk;
    logic [7:0] err;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Ori = 1'b1;
  logic       En  = 1'b0;
  logic [3:0] Q   = 4'b0000;
  logic [1:0] Idx;
  logic       Valid, Illegal, SeqErr, Locked;
  logic [7:0] ErrCnt;

  logic       En2 = 1'b0;
  logic [3:0] Q2  = 4'b0000;
  logic [1:0] Idx2;
  logic       Valid2, Illegal2, SeqErr2, Locked2;
  logic [1:0] ErrCnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #20 Clk = ~Clk;

  ring4b_monitor #(.N(4), .DIR(0), .LOCK_CNT(3), .ERR_W(8)) dut (
    .Clk(Clk), .Ori(Ori), .En(En), .Q(Q),
    .Idx(Idx), .Valid(Valid), .Illegal(Illegal), .SeqErr(SeqErr),
    .Locked(Locked), .ErrCnt(ErrCnt)
  );

  ring4b_monitor #(.N(4), .DIR(0), .LOCK_CNT(3), .ERR_W(2)) dut_e2 (
    .Clk(Clk), .Ori(Ori), .En(En2), .Q(Q2),
    .Idx(Idx2), .Valid(Valid2), .Illegal(Illegal2), .SeqErr(SeqErr2),
    .Locked(Locked2), .ErrCnt(ErrCnt2)
  );

  function automatic logic [13:0] obs();
    return {Idx, Valid, Illegal, SeqErr, Locked, ErrCnt};
  endfunction

  task automatic drive(input logic e, input logic [3:0] q);
    @(negedge Clk);
    En = e;
    Q  = q;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Ori = 1'b1;
    #5;
    n_cmp++;
    if (obs() !== 14'd0 || Locked2 !== 1'b0 || ErrCnt2 !== 2'd0) begin
      n_bad++;
      $display("FAIL reset: got %b/%b%b want 0", obs(), Locked2, ErrCnt2);
    end
    @(negedge Clk);
    Ori = 1'b0;
  endtask

  task automatic test_lock_sequence();
    vec_t t[5] = '{
      '{4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
      '{4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
      '{4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0},
      '{4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0},
      '{4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}};
    foreach (t[i]) begin
      drive(1'b1, t[i].q);
      n_cmp++;
      if (obs() !== {t[i].idx, t[i].v, t[i].il, t[i].se, t[i].lk, t[i].err}) begin
        n_bad++;
        $display("FAIL lock_seq[%0d]: got %b want %b", i, obs(), t[i][13:0]);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t t[2] = '{
      '{4'b0110, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1},
      '{4'b0110, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}};
    foreach (t[i]) begin
      drive(i == 0, t[i].q);
      n_cmp++;
      if (obs() !== {t[i].idx, t[i].v, t[i].il, t[i].se, t[i].lk, t[i].err}) begin
        n_bad++;
        $display("FAIL illegal[%0d]: got %b want %b", i, obs(), t[i][13:0]);
      end
    end
  endtask

  task automatic test_skip();
    vec_t t[7] = '{
      '{4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
      '{4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
      '{4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1},
      '{4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1},
      '{4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2},
      '{4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2},
      '{4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2}};
    foreach (t[i]) begin
      drive(1'b1, t[i].q);
      n_cmp++;
      if (obs() !== {t[i].idx, t[i].v, t[i].il, t[i].se, t[i].lk, t[i].err}) begin
        n_bad++;
        $display("FAIL skip[%0d]: got %b want %b", i, obs(), t[i][13:0]);
      end
    end
  endtask

  task automatic test_stuck_and_hold();
    vec_t t[4] = '{
      '{4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2},
      '{4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3},
      '{4'b1111, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3},
      '{4'b1111, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3}};
    foreach (t[i]) begin
      drive(i < 2, t[i].q);
      n_cmp++;
      if (obs() !== {t[i].idx, t[i].v, t[i].il, t[i].se, t[i].lk, t[i].err}) begin
        n_bad++;
        $display("FAIL stuck_hold[%0d]: got %b want %b", i, obs(), t[i][13:0]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_err[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      En2 = 1'b1;
      Q2  = 4'b0000;
      @(posedge Clk);
      #1;
      n_cmp++;
      if ({Valid2, Illegal2, SeqErr2, ErrCnt2} !== {1'b0, 1'b1, 1'b0, exp_err[i]}) begin
        n_bad++;
        $display("FAIL saturate[%0d]: got v%b il%b se%b err%0d want v0 il1 se0 err%0d",
                 i, Valid2, Illegal2, SeqErr2, ErrCnt2, exp_err[i]);
      end
    end
    @(negedge Clk);
    En2 = 1'b0;
  endtask

  task automatic test_async_reset();
    vec_t t[3] = '{
      '{4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
      '{4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
      '{4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}};
    drive(1'b1, 4'b0001);
    drive(1'b1, 4'b0010);
    drive(1'b1, 4'b0100);
    n_cmp++;
    if (Locked !== 1'b1) begin
      n_bad++;
      $display("FAIL async_pre_lock: got Locked=%b want 1", Locked);
    end
    @(negedge Clk);
    En  = 1'b0;
    Ori = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 14'd0) begin
      n_bad++;
      $display("FAIL async_clear: got %b want 0", obs());
    end
    #5;
    Ori = 1'b0;
    foreach (t[i]) begin
      drive(1'b1, t[i].q);
      n_cmp++;
      if (obs() !== {t[i].idx, t[i].v, t[i].il, t[i].se, t[i].lk, t[i].err}) begin
        n_bad++;
        $display("FAIL relock[%0d]: got %b want %b", i, obs(), t[i][13:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_illegal();
    test_skip();
    test_stuck_and_hold();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
